// File: rtl/resp_window_checker.sv
// Response window checker.
// A trig opens a window of WINDOW cycles. A response event (ev) inside the
// window produces a one-cycle pass and records its latency. No response by the
// end of the window latches a sticky fail and bumps a saturating timeout
// counter. clr aborts an open window and clears a latched fail.
module resp_window_checker #(
  parameter int WINDOW = 4,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             ev,
  input  logic             clr,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W:0]   last_lat,
  output logic [7:0]       fail_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } state_t;

  // The last in-window counter value before the window expires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   LAT_ONE  = (CNT_W + 1)'(1);
  localparam logic [7:0]       FAIL_MAX = 8'hFF;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   last_lat_q, last_lat_d;
  logic [7:0]       fail_cnt_q, fail_cnt_d;

  // Next-state and datapath update for the window FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_lat_d = last_lat_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      IDLE: begin
        // clr suppresses a same-cycle trig; ev here belongs to no window.
        if (!clr && trig) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end

      ARMED: begin
        // clr wins over a response and over the timeout; trig never restarts.
        if (clr) begin
          state_d = IDLE;
        end else if (ev) begin
          state_d    = HIT;
          last_lat_d = {1'b0, cnt_q} + LAT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = MISS;
          if (fail_cnt_q != FAIL_MAX) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HIT: begin
        // A back-to-back trig reopens the window straight from the pass cycle.
        if (!clr && trig) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      MISS: begin
        // The fail flag is sticky until explicitly cleared.
        if (clr) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_lat_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_lat_q <= last_lat_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // Moore decodes of the state register.
  assign busy     = (state_q == ARMED);
  assign pass     = (state_q == HIT);
  assign fail     = (state_q == MISS);
  assign last_lat = last_lat_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_resp_window_checker.sv
// Directed bench for resp_window_checker with WINDOW=4, CNT_W=3.
// Cycle n means inputs held during cycle n are sampled at the rising edge that
// ends it; outputs for cycle n+1 are read 1 time unit after that edge.
module tb_resp_window_checker;

  localparam int WINDOW = 4;
  localparam int CNT_W  = 3;

  logic           clk;
  logic           reset;
  logic           trig;
  logic           ev;
  logic           clr;
  logic           busy;
  logic           pass;
  logic           fail;
  logic [CNT_W:0] last_lat;
  logic [7:0]     fail_cnt;

  int vec_cnt;
  int err_cnt;

  resp_window_checker #(
    .WINDOW(WINDOW),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .trig    (trig),
    .ev      (ev),
    .clr     (clr),
    .busy    (busy),
    .pass    (pass),
    .fail    (fail),
    .last_lat(last_lat),
    .fail_cnt(fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle; outputs are stable 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic b, input logic p, input logic f);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".pass"}, 32'(pass), 32'(p));
    check({tag, ".fail"}, 32'(fail), 32'(f));
  endtask

  task automatic set_in(input logic t, input logic e, input logic c);
    trig = t;
    ev   = e;
    clr  = c;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b0;
    set_in(1'b1, 1'b1, 1'b0);

    // Reset wins over trig/ev.
    tick();
    tick();
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst.last_lat", 32'(last_lat), 32'd0);
    check("rst.fail_cnt", 32'(fail_cnt), 32'd0);
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    tick();
    check_flags("idle", 1'b0, 1'b0, 1'b0);

    // Pass: trig in c0, ev in c2 -> pass in c3, last_lat=2.
    set_in(1'b1, 1'b0, 1'b0); tick();          // now c1
    check_flags("p.c1", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0); tick();          // c2
    check_flags("p.c2", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b0); tick();          // c3
    check_flags("p.c3", 1'b0, 1'b1, 1'b0);
    check("p.last_lat", 32'(last_lat), 32'd2);
    check("p.fail_cnt", 32'(fail_cnt), 32'd0);
    set_in(1'b0, 1'b0, 1'b0); tick();          // c4
    check_flags("p.c4", 1'b0, 1'b0, 1'b0);

    // Timeout: busy c1..c4, fail from c5; trig/ev ignored in MISS; clr c8.
    set_in(1'b1, 1'b0, 1'b0); tick();          // c1
    set_in(1'b0, 1'b0, 1'b0);
    check_flags("t.c1", 1'b1, 1'b0, 1'b0);
    tick(); check_flags("t.c2", 1'b1, 1'b0, 1'b0);
    tick(); check_flags("t.c3", 1'b1, 1'b0, 1'b0);
    tick(); check_flags("t.c4", 1'b1, 1'b0, 1'b0);
    tick();                                    // c5
    check_flags("t.c5", 1'b0, 1'b0, 1'b1);
    check("t.fail_cnt", 32'(fail_cnt), 32'd1);
    check("t.last_lat", 32'(last_lat), 32'd2);
    set_in(1'b1, 1'b0, 1'b0); tick();          // c6 (trig ignored)
    check_flags("t.c6", 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b1, 1'b0); tick();          // c7 (ev ignored)
    check_flags("t.c7", 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0); tick();          // c8
    check_flags("t.c8", 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b1); tick();          // c9
    check_flags("t.c9", 1'b0, 1'b0, 1'b0);
    check("t.fail_cnt2", 32'(fail_cnt), 32'd1);

    // Edge response: trig+ev in c0, ev in c4 -> pass c5 lat 4; trig in HIT.
    set_in(1'b1, 1'b1, 1'b0); tick();          // c1
    check_flags("e.c1", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();                    // c4
    check_flags("e.c4", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b0); tick();          // c5
    check_flags("e.c5", 1'b0, 1'b1, 1'b0);
    check("e.last_lat", 32'(last_lat), 32'd4);
    set_in(1'b1, 1'b0, 1'b0); tick();          // c6
    check_flags("e.c6", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b1); tick();          // c7: clr abort
    check_flags("e.c7", 1'b0, 1'b0, 1'b0);
    check("e.fail_cnt", 32'(fail_cnt), 32'd1);

    // Abort: clr and ev together in c2 -> IDLE in c3, no pass, lat unchanged.
    set_in(1'b1, 1'b0, 1'b0); tick();          // c1
    set_in(1'b0, 1'b0, 1'b0); tick();          // c2
    check_flags("a.c2", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b1); tick();          // c3
    check_flags("a.c3", 1'b0, 1'b0, 1'b0);
    check("a.last_lat", 32'(last_lat), 32'd4);
    set_in(1'b0, 1'b0, 1'b0); tick();          // c4
    check_flags("a.c4", 1'b0, 1'b0, 1'b0);

    // clr in IDLE suppresses a same-cycle trig.
    set_in(1'b1, 1'b0, 1'b1); tick();
    check_flags("ic", 1'b0, 1'b0, 1'b0);

    // Reset mid-window: reset=0 in c2 with ev -> all zero in c3, no pulses.
    set_in(1'b1, 1'b0, 1'b0); tick();          // c1
    check_flags("r.c1", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0); tick();          // c2
    reset = 1'b0;
    set_in(1'b0, 1'b1, 1'b0); tick();          // c3
    check_flags("r.c3", 1'b0, 1'b0, 1'b0);
    check("r.last_lat", 32'(last_lat), 32'd0);
    check("r.fail_cnt", 32'(fail_cnt), 32'd0);
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0); tick();          // c4
    check_flags("r.c4", 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0); tick();          // new window accepted
    check_flags("r.new", 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b1); tick();
    check_flags("r.abort", 1'b0, 1'b0, 1'b0);

    // Saturation: 256 timeouts each followed by clr.
    for (int n = 1; n <= 256; n++) begin
      set_in(1'b1, 1'b0, 1'b0); tick();
      set_in(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < WINDOW; k++) tick();
      if (n == 1 || n == 254 || n == 255 || n == 256) begin
        check_flags($sformatf("s.%0d", n), 1'b0, 1'b0, 1'b1);
        check($sformatf("s.fail_cnt%0d", n), 32'(fail_cnt), (n > 255) ? 32'd255 : 32'(n));
      end
      set_in(1'b0, 1'b0, 1'b1); tick();
      set_in(1'b0, 1'b0, 1'b0);
    end
    check_flags("s.end", 1'b0, 1'b0, 1'b0);
    check("s.hold", 32'(fail_cnt), 32'd255);
    check("s.last_lat", 32'(last_lat), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
